// File: rtl/pipe_stage_reg.sv
// Flow-controlled WIDTH-bit pipeline stage register with synchronous flush.
// Define PIPE_STAGE_SKID_EN to add a skid entry so that in_ready comes from a flop.
module pipe_stage_reg #(
  parameter int              WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       count
);

  // Handshake: a beat moves on a rising edge when valid & ready are both high;
  // valid never waits on ready, and a held beat keeps its data stable.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1
`ifdef PIPE_STAGE_SKID_EN
    ,
    ST_FULL  = 2'd2
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic             out_valid_q, out_valid_d;
  logic             fire_in, fire_out;

`ifdef PIPE_STAGE_SKID_EN
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic [1:0]       count_q, count_d;

  assign in_ready = in_ready_q;
  assign count    = count_q;
`else
  assign in_ready = !out_valid_q | out_ready;
  assign count    = {1'b0, out_valid_q};
`endif

  assign fire_in   = in_valid & in_ready;
  assign fire_out  = out_valid_q & out_ready;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
`ifdef PIPE_STAGE_SKID_EN
    skid_d  = skid_q;
`endif
    if (flush) begin
      // Squash wins; any accepted input beat is dropped without loading data.
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (fire_in) begin
            main_d  = in_data;
            state_d = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (fire_in && fire_out) begin
            main_d = in_data;
          end else if (fire_in) begin
`ifdef PIPE_STAGE_SKID_EN
            skid_d  = in_data;
            state_d = ST_FULL;
`endif
          end else if (fire_out) begin
            state_d = ST_EMPTY;
          end
        end
`ifdef PIPE_STAGE_SKID_EN
        ST_FULL: begin
          if (out_ready) begin
            main_d  = skid_q;
            state_d = ST_BUSY;
          end
        end
`endif
        default: state_d = ST_EMPTY;
      endcase
    end

    out_valid_d = (state_d != ST_EMPTY);
`ifdef PIPE_STAGE_SKID_EN
    in_ready_d = (state_d != ST_FULL);
    case (state_d)
      ST_BUSY: count_d = 2'd1;
      ST_FULL: count_d = 2'd2;
      default: count_d = 2'd0;
    endcase
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_q      <= RESET_VALUE;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_q     <= RESET_VALUE;
      in_ready_q <= 1'b1;
      count_q    <= 2'd0;
    end else begin
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      count_q    <= count_d;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: stimulus pushes expected beats into a queue,
// a monitor pops and compares on every output transfer.
module tb_pipe_stage_reg;
  localparam int          W       = 32;
  localparam logic [W-1:0] RST_VAL = 32'hDEAD_BEEF;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         flush = 1'b0;
  logic [1:0]   count;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  pipe_stage_reg #(.WIDTH(W), .RESET_VALUE(RST_VAL)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush(flush), .count(count)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_beat actual=%h required=no_beat", out_data);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          errors++;
          $display("FAIL out_beat actual=%h required=%h", out_data, e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
  endtask

  // Apply inputs just after a rising edge, return at the following falling edge.
  task automatic cyc(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    @(posedge clk); #1;
    drive(v, d, r, f);
    @(negedge clk);
  endtask

  initial begin
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_count",     {30'd0, count}, 0);
    chk("rst_out_data",  out_data, RST_VAL);
    chk("rst_in_ready",  {31'd0, in_ready}, 1);

    // streaming: first beat on first edge after reset release
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1, 32'h1, 1, 0); exp_q.push_back(32'h1);
    @(negedge clk);
    cyc(1, 32'h2, 1, 0); exp_q.push_back(32'h2);
    chk("stream_count", {30'd0, count}, 1);
    cyc(1, 32'h3, 1, 0); exp_q.push_back(32'h3);
    cyc(0, 0, 1, 0);
    chk("stream_valid", {31'd0, out_valid}, 1);
    cyc(0, 0, 1, 0);
    chk("empty_valid", {31'd0, out_valid}, 0);
    chk("empty_keep_data", out_data, 32'h3);

    // simultaneous in/out transfer in BUSY
    cyc(1, 32'h5, 0, 0); exp_q.push_back(32'h5);
    cyc(1, 32'h6, 1, 0); exp_q.push_back(32'h6);
    chk("sim_hold5", out_data, 32'h5);
    cyc(0, 0, 1, 0);
    chk("sim_data6", out_data, 32'h6);
    chk("sim_count", {30'd0, count}, 1);
    cyc(0, 0, 0, 0);
    chk("sim_drain", {30'd0, count}, 0);

`ifdef PIPE_STAGE_SKID_EN
    // backpressure into the skid entry
    cyc(1, 32'hA, 0, 0); exp_q.push_back(32'hA);
    cyc(1, 32'hB, 0, 0); exp_q.push_back(32'hB);
    chk("skid_rdy_busy", {31'd0, in_ready}, 1);
    cyc(0, 0, 0, 0);
    chk("full_count", {30'd0, count}, 2);
    chk("full_in_ready", {31'd0, in_ready}, 0);
    chk("full_data", out_data, 32'hA);
    cyc(0, 0, 1, 0);
    chk("full_rdy_stays", {31'd0, in_ready}, 0);
    cyc(0, 0, 1, 0);
    chk("exit_in_ready", {31'd0, in_ready}, 1);
    chk("exit_count", {30'd0, count}, 1);
    chk("exit_data", out_data, 32'hB);
    cyc(0, 0, 0, 0);
    chk("skid_drain", {30'd0, count}, 0);
`else
    // backpressure without skid: in_ready follows out_ready combinationally
    cyc(1, 32'h7, 0, 0); exp_q.push_back(32'h7);
    cyc(1, 32'h8, 0, 0);
    chk("bp_in_ready", {31'd0, in_ready}, 0);
    chk("bp_data", out_data, 32'h7);
    cyc(1, 32'h8, 0, 0);
    chk("bp_hold_data", out_data, 32'h7);
    chk("bp_count", {30'd0, count}, 1);
    cyc(1, 32'h8, 1, 0); exp_q.push_back(32'h8);
    chk("bp_rdy_release", {31'd0, in_ready}, 1);
    cyc(0, 0, 1, 0);
    chk("bp_data8", out_data, 32'h8);
    cyc(0, 0, 0, 0);
    chk("bp_drain", {30'd0, count}, 0);
`endif

    // flush in BUSY: output beat completes, input beat discarded
    cyc(1, 32'hC, 0, 0); exp_q.push_back(32'hC);
    cyc(1, 32'hE, 1, 1);
    cyc(0, 0, 1, 0);
    chk("flb_valid", {31'd0, out_valid}, 0);
    chk("flb_count", {30'd0, count}, 0);
    chk("flb_data", out_data, 32'hC);
    cyc(0, 0, 1, 0);

`ifdef PIPE_STAGE_SKID_EN
    // flush in FULL with an offered beat
    cyc(1, 32'h11, 0, 0);
    cyc(1, 32'h12, 0, 0);
    cyc(1, 32'h13, 0, 1);
    chk("flf_pre_count", {30'd0, count}, 2);
    cyc(0, 0, 1, 0);
    chk("flf_count", {30'd0, count}, 0);
    chk("flf_valid", {31'd0, out_valid}, 0);
    chk("flf_data", out_data, 32'h11);
    cyc(0, 0, 1, 0);
`endif

    // asynchronous reset with a held beat
    cyc(1, 32'h21, 0, 0);
    cyc(0, 0, 0, 0);
    chk("mid_valid_pre", {31'd0, out_valid}, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 0);
    chk("mid_rst_count", {30'd0, count}, 0);
    chk("mid_rst_data", out_data, RST_VAL);
    chk("mid_rst_ready", {31'd0, in_ready}, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1, 32'h22, 1, 0); exp_q.push_back(32'h22);
    @(negedge clk);
    cyc(0, 0, 1, 0);
    chk("post_rst_data", out_data, 32'h22);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);

    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
